// File: rtl/ledger_pkg.sv
// Shared encodings for the user ledger: ops, result codes, FSM states, lock threshold.
package ledger_pkg;
  localparam logic [1:0] OP_QUERY    = 2'd0;
  localparam logic [1:0] OP_CHARGE   = 2'd1;
  localparam logic [1:0] OP_RECHARGE = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [2:0] {
    CODE_OK       = 3'd0,
    CODE_NO_FUNDS = 3'd1,
    CODE_OVERFLOW = 3'd2,
    CODE_BAD_ID   = 3'd3,
    CODE_BAD_OP   = 3'd4,
    CODE_LOCKED   = 3'd5
  } code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT,
    S_RESP
  } state_t;

  localparam logic [1:0] LOCK_MAX = 2'd3;
endpackage

// File: rtl/ledger_alu.sv
// Combinational balance arithmetic and result-code selection for one ledger transaction.
module ledger_alu
  import ledger_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] bal,
  input  logic [AMT_W-1:0] amount,
  input  logic             id_ok,
  input  logic             locked,
  output logic [AMT_W-1:0] new_bal,
  output code_t            code
);
  logic [AMT_W:0] sum;

  assign sum = {1'b0, bal} + {1'b0, amount};

  // Priority: bad id, bad op, lock, then the arithmetic outcome.
  always_comb begin
    new_bal = bal;
    code    = CODE_OK;
    if (!id_ok) begin
      code    = CODE_BAD_ID;
      new_bal = '0;
    end else if (op == OP_RSVD) begin
      code = CODE_BAD_OP;
    end else if (locked && (op != OP_RECHARGE)) begin
      code = CODE_LOCKED;
    end else begin
      case (op)
        OP_CHARGE: begin
          if (amount > bal) code = CODE_NO_FUNDS;
          else              new_bal = bal - amount;
        end
        OP_RECHARGE: begin
          if (sum[AMT_W]) code = CODE_OVERFLOW;
          else            new_bal = sum[AMT_W-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/user_ledger.sv
// Per-user balance ledger with a 4-state request/check/commit/respond FSM.
// Optional USER_LEDGER_LOCK_EN adds per-account failed-charge lockout.
module user_ledger
  import ledger_pkg::*;
#(
  parameter int NUM_USERS = 8,
  parameter int ID_W      = 3,
  parameter int AMT_W     = 16,
  parameter int INIT_BAL  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ID_W-1:0]  req_id,
  input  logic [AMT_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [2:0]       rsp_code,
  output logic [AMT_W-1:0] rsp_balance
);
  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  state_t           state;
  logic [1:0]       op_q;
  logic [ID_W-1:0]  id_q;
  logic [AMT_W-1:0] amt_q;
  code_t            code_q;
  logic [AMT_W-1:0] nbal_q;
  logic [AMT_W-1:0] bal_mem [NUM_USERS];

  logic [IDX_W-1:0] idx;
  logic             id_ok;
  logic             locked;
  logic [AMT_W-1:0] cur_bal;
  logic [AMT_W-1:0] alu_bal;
  code_t            alu_code;
  logic             commit;

  assign idx     = id_q[IDX_W-1:0];
  assign id_ok   = ({1'b0, id_q} < (ID_W+1)'(NUM_USERS));
  assign cur_bal = bal_mem[idx];
  assign commit  = (state == S_COMMIT) && (code_q == CODE_OK);

  ledger_alu #(.AMT_W(AMT_W)) u_alu (
    .op      (op_q),
    .bal     (cur_bal),
    .amount  (amt_q),
    .id_ok   (id_ok),
    .locked  (locked),
    .new_bal (alu_bal),
    .code    (alu_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_ok      <= 1'b0;
      rsp_code    <= '0;
      rsp_balance <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_CHECK;
          req_ready <= 1'b0;
        end
        S_CHECK: state <= S_COMMIT;
        S_COMMIT: begin
          state       <= S_RESP;
          rsp_valid   <= 1'b1;
          rsp_ok      <= (code_q == CODE_OK);
          rsp_code    <= code_q;
          rsp_balance <= nbal_q;
        end
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transaction data registers need no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      op_q  <= req_op;
      id_q  <= req_id;
      amt_q <= req_amount;
    end
    if (state == S_CHECK) begin
      code_q <= alu_code;
      nbal_q <= alu_bal;
    end
  end

  // A reset landing in the COMMIT cycle wins over the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) bal_mem[i] <= AMT_W'(INIT_BAL);
    end else if (commit) begin
      bal_mem[idx] <= nbal_q;
    end
  end

`ifdef USER_LEDGER_LOCK_EN
  logic [1:0] lock_cnt [NUM_USERS];

  assign locked = (lock_cnt[idx] == LOCK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) lock_cnt[i] <= '0;
    end else if (state == S_COMMIT) begin
      if (code_q == CODE_NO_FUNDS && lock_cnt[idx] != LOCK_MAX)
        lock_cnt[idx] <= lock_cnt[idx] + 2'd1;
      else if (code_q == CODE_OK && op_q != OP_QUERY)
        lock_cnt[idx] <= '0;
    end
  end
`else
  assign locked = 1'b0;
`endif
endmodule
